ps2_keyboard_fifo: RTL and testbench

Parametrised PS/2 keyboard receiver: synchronises the raw `ps2_clk`/`ps2_data` pins and deframes 11-bit PS/2 frames with full start/parity/stop checking. It also recovers stalled frames with a watchdog and folds `E0`/`F0` prefix bytes into flags on the following scan code. Completed key events are buffered in a show-ahead FIFO read through a valid/ready handshake. It replaces print-only receivers and feeds keyboard consumers (scan-code-to-ASCII, display logic) in NVBoard designs.

---
 rtl/ps2_keyboard_fifo.sv | 161 ++++++++++++++++
 tb/tb_ps2_keyboard_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard receiver: pin synchroniser, checked 11-bit frame deframer with watchdog,
// E0/F0 prefix folding and a show-ahead key-event FIFO read via valid/ready.
module ps2_keyboard_fifo #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SYNC_STAGES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_code,
    output logic                          out_break,
    output logic                          out_ext,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   data_s;
    logic [3:0]             bit_cnt;
    logic [9:0]             shreg;
    logic [WW-1:0]          wd;
    logic                   frame_ok;
    logic                   ext_pend;
    logic                   brk_pend;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic [9:0]             entry;
    logic [9:0]             mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;

    // Pin synchronisers idle high so leaving reset never looks like a clock fall
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign data_s = dat_sync[SYNC_STAGES-1];

    // Frame deframer; frame status is judged on the stop-bit fall so CHECK only routes the byte
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bit_cnt   <= 4'd0;
            shreg     <= 10'd0;
            wd        <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    wd <= '0;
                    if (fall && !data_s) begin
                        state   <= S_SHIFT;
                        bit_cnt <= 4'd0;
                    end
                end
                S_SHIFT: begin
                    if (fall) begin
                        wd      <= '0;
                        shreg   <= {data_s, shreg[9:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd9) begin
                            state     <= S_CHECK;
                            frame_ok  <= (^shreg[9:1]) & data_s;
                            frame_err <= ~((^shreg[9:1]) & data_s);
                        end
                    end else if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
                        state     <= S_IDLE;
                        wd        <= '0;
                        frame_err <= 1'b1;
                    end else begin
                        wd <= wd + WW'(1);
                    end
                end
                S_CHECK: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign push  = (state == S_CHECK) && frame_ok &&
                   (shreg[7:0] != 8'hE0) && (shreg[7:0] != 8'hF0);
    assign entry = {brk_pend, ext_pend, shreg[7:0]};

    // Prefix flags attach to the next non-prefix byte; any frame error drops them
    always_ff @(posedge clk) begin
        if (rst || frame_err) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (state == S_CHECK && frame_ok) begin
            if (shreg[7:0] == 8'hE0) begin
                ext_pend <= 1'b1;
            end else if (shreg[7:0] == 8'hF0) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    assign full = (fill == FW'(FIFO_DEPTH));
    assign pop  = out_valid & out_ready;

    // Circular buffer; a push into a full FIFO only succeeds when the head leaves the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= 10'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push && (!full || pop)) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && full && !pop) overflow <= 1'b1;
            case ({push && (!full || pop), pop})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
        end
    end

    assign out_valid                      = (fill != '0);
    assign {out_break, out_ext, out_code} = mem[rd_ptr];

endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// Directed bench for ps2_keyboard_fifo: bit-banged PS/2 frames, popped events logged by a monitor.
module tb_ps2_keyboard_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned SYNC  = 3;
    localparam int unsigned TO    = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_code;
    logic       out_break;
    logic       out_ext;
    logic [3:0] fill;
    logic       frame_err;
    logic       overflow;

    int         n_vec = 0;
    int         n_err = 0;
    int         err_cnt = 0;
    int         base;
    int         e0;
    logic [9:0] got_q [$];

    ps2_keyboard_fifo #(
        .FIFO_DEPTH    (DEPTH),
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_code (out_code),
        .out_break(out_break),
        .out_ext  (out_ext),
        .fill     (fill),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Log every accepted head entry and count frame_err pulses
    always @(posedge clk) begin
        if (out_valid && out_ready) got_q.push_back({out_break, out_ext, out_code});
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_raw(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) send_bit(f[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic par_flip, input logic stop);
        logic par;
        par = (~^b) ^ par_flip;
        send_raw({stop, par, b, 1'b0}, 11);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 2000; i++) begin
            if (fill == 4'd0) break;
            @(negedge clk);
        end
        check(tag, 32'(fill), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_fill"},  32'(fill),      32'd0);
        check({tag, "_ferr"},  32'(frame_err), 32'd0);
        check({tag, "_ovf"},   32'(overflow),  32'd0);
        check({tag, "_code"},  32'(out_code),  32'd0);
        check({tag, "_brk"},   32'(out_break), 32'd0);
        check({tag, "_ext"},   32'(out_ext),   32'd0);
    endtask

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst");

        // Make code with consumer ready
        out_ready = 1'b1;
        base = got_q.size(); e0 = err_cnt;
        send_byte(8'h1C, 1'b0, 1'b1);
        check("make_cnt",  32'(got_q.size() - base), 32'd1);
        check("make_ent",  32'(got_q[base]), 32'h01C);
        check("make_fill", 32'(fill), 32'd0);
        check("make_err",  32'(err_cnt - e0), 32'd0);

        // Prefix folding: F0 1C then E0 F0 75
        base = got_q.size();
        send_byte(8'hF0, 1'b0, 1'b1);
        send_byte(8'h1C, 1'b0, 1'b1);
        send_byte(8'hE0, 1'b0, 1'b1);
        send_byte(8'hF0, 1'b0, 1'b1);
        send_byte(8'h75, 1'b0, 1'b1);
        check("pfx_cnt", 32'(got_q.size() - base), 32'd2);
        check("pfx_e0",  32'(got_q[base]),     32'h21C);
        check("pfx_e1",  32'(got_q[base + 1]), 32'h375);
        check("pfx_err", 32'(err_cnt - e0), 32'd0);

        // Bad parity, bad stop, then a good frame
        base = got_q.size(); e0 = err_cnt;
        send_byte(8'h1C, 1'b1, 1'b1);
        check("par_err",  32'(err_cnt - e0), 32'd1);
        check("par_fill", 32'(fill), 32'd0);
        send_byte(8'h1C, 1'b0, 1'b0);
        check("stop_err", 32'(err_cnt - e0), 32'd2);
        check("stop_cnt", 32'(got_q.size() - base), 32'd0);
        send_byte(8'h1C, 1'b0, 1'b1);
        check("good_cnt", 32'(got_q.size() - base), 32'd1);
        check("good_ent", 32'(got_q[base]), 32'h01C);

        // Overflow: nine codes into an eight-entry FIFO
        out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b0, 1'b1);
        check("ovf_fill",  32'(fill), 32'd8);
        check("ovf_flag",  32'(overflow), 32'd1);
        check("ovf_head",  32'(out_code), 32'h01);
        base = got_q.size();
        out_ready = 1'b1;
        wait_empty("ovf_drain");
        check("ovf_cnt", 32'(got_q.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) check("ovf_order", 32'(got_q[base + i]), 32'(i + 1));
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Simultaneous push/pop on a full FIFO
        out_ready = 1'b0;
        rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
        check("pp_ovf_clr", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h11 + i), 1'b0, 1'b1);
        check("pp_full", 32'(fill), 32'd8);
        base = got_q.size();
        send_raw({1'b1, ~^8'h19, 8'h19, 1'b0}, 10);
        @(negedge clk) ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
        check("pp_fill", 32'(fill), 32'd8);
        check("pp_ovf",  32'(overflow), 32'd0);
        out_ready = 1'b1;
        wait_empty("pp_drain");
        check("pp_cnt",  32'(got_q.size() - base), 32'd9);
        check("pp_head", 32'(got_q[base]), 32'h011);
        check("pp_tail", 32'(got_q[base + 8]), 32'h019);

        // Watchdog: E0, stalled partial frame, then a clean 2A without the stale prefix
        e0 = err_cnt; base = got_q.size();
        send_byte(8'hE0, 1'b0, 1'b1);
        send_raw({1'b1, 1'b0, 8'h2A, 1'b0}, 5);
        repeat (TO + 20) @(negedge clk);
        check("wd_err", 32'(err_cnt - e0), 32'd1);
        send_byte(8'h2A, 1'b0, 1'b1);
        check("wd_cnt", 32'(got_q.size() - base), 32'd1);
        check("wd_ent", 32'(got_q[base]), 32'h02A);
        check("wd_err2", 32'(err_cnt - e0), 32'd1);

        // Reset mid-frame with a stored entry and a pending break prefix
        out_ready = 1'b0;
        send_byte(8'h33, 1'b0, 1'b1);
        send_byte(8'hF0, 1'b0, 1'b1);
        check("mr_pre_fill", 32'(fill), 32'd1);
        send_raw({1'b1, 1'b0, 8'h4B, 1'b0}, 6);
        rst = 1'b1; repeat (2) @(negedge clk);
        check_reset_outputs("mr");
        rst = 1'b0;
        out_ready = 1'b1;
        base = got_q.size(); e0 = err_cnt;
        send_byte(8'h4B, 1'b0, 1'b1);
        check("mr_cnt", 32'(got_q.size() - base), 32'd1);
        check("mr_ent", 32'(got_q[base]), 32'h04B);
        check("mr_err", 32'(err_cnt - e0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
